spi_port: RTL and testbench
===========================

SPI_PORT -- requirements
Module: spi_port

Interface
REQ-001 SHALL have port sclk, input, 1, serial clock and the only clock; all state changes on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset sampled on rising sclk.
REQ-003 SHALL have port csb, input, 1, active-low frame select sampled on rising sclk.
REQ-004 SHALL have port sdi, input, 1, serial data in, MSB first, sampled on rising sclk.
REQ-005 SHALL have port sdo, output, 1, serial read data, driven 0 when sdo_en low.
REQ-006 SHALL have port sdo_en, output, 1, high while read data is being driven (external tri-state enable).
REQ-007 SHALL have port Addr, output, 13, current register address for the parent's write-strobe and read-mux decode.
REQ-008 SHALL have port WrStb, output, 1, write strobe to register file, combinational, active during the cycle ending in the 8th bit of a write byte.
REQ-009 SHALL have port WrData, output, 8, write byte, combinational, valid whenever WrStb is high.
REQ-010 SHALL have port RdData, input, 8, combinational read data from the parent's mux, selected by Addr.
REQ-011 SHALL have port FrameErr, output, 1, one-cycle pulse flagging a frame that ended mid-word.

Function
REQ-012 SHALL implement states INSTR, WRITE, READ, DONE; a 4-bit instruction bit counter; a 3-bit data bit counter; a 2-bit byte counter.
REQ-013 Frame format SHALL be 16-bit instruction then data bytes: bit15 R/Wn (1 = read), bits14:13 W (00=1, 01=2, 10=3 bytes, 11=stream until csb high), bits12:0 start address.
REQ-014 At any edge with csb high: state SHALL go to INSTR, all counters clear, no write occurs; the master supplies at least one sclk rising edge with csb high between frames.
REQ-015 INSTR: edges 1-16 of a frame shift sdi into the instruction register; at edge 16 Addr SHALL load {shift[11:0], sdi}, W and R/Wn latch, state goes to READ or WRITE with data bit counter 0.
REQ-016 WRITE: sdi shifts into the data shift register; WrStb SHALL be high exactly when state=WRITE, data bit counter=7 and csb low; WrData SHALL equal {shift[6:0], sdi}, so the parent captures the byte on the 8th data edge.
REQ-017 READ: sdo_en SHALL be high when state=READ and csb low (combinational on csb); sdo SHALL equal RdData[7 - data bit counter], valid from one rising edge to the next; master samples on the intervening falling edge.
REQ-018 At the edge completing each data byte (counter 7 -> 0), Addr SHALL decrement by 1, wrapping 0x0000 -> 0x1FFF.
REQ-019 For W != 11, after W+1 bytes the state SHALL go to DONE; DONE ignores sdi, WrStb stays low, sdo_en stays low until csb high.
REQ-020 For W = 11 the block SHALL continue byte transfers with address decrement until csb high; no byte limit.
REQ-021 FrameErr SHALL pulse for one cycle at the first csb-high edge following a frame that ended with instruction count 1-15 or data bit count 1-7; no register write results from the partial byte.
REQ-022 R/Wn and W SHALL be fixed for the whole frame; no mid-frame direction change.

Reset
REQ-023 With reset high at a rising edge: state INSTR, counters 0, Addr 0x0000, FrameErr 0; hence WrStb 0, sdo_en 0, sdo 0; reset SHALL take priority over csb.
REQ-024 Reset asserted mid-frame SHALL abandon the frame without WrStb and without FrameErr; the next frame after csb high starts clean.

Verification
REQ-025 Single write: instr 0x0014, data 0xA5 -> Addr=0x0014 after edge 16, WrStb high only during edge 24 with WrData=0xA5, then DONE.
REQ-026 3-byte write: instr 0x4100, data 0x11,0x22,0x33 -> WrStb at edges 24/32/40 with Addr 0x0100/0x00FF/0x00FE respectively; extra clocks in DONE produce no WrStb.
REQ-027 Single read: instr 0x8008, RdData=0x3C -> sdo_en high after edge 16, sdo sequence 0,0,1,1,1,1,0,0, sdo_en low after edge 24.
REQ-028 Streaming read wrap: instr 0xE001, 3 bytes -> Addr 0x0001, 0x0000, 0x1FFF per byte; stops cleanly at csb high.
REQ-029 Aborted frame: csb high after 20 edges of a write -> no WrStb, FrameErr pulses one cycle at first csb-high edge.
REQ-030 Reset at edge 10 of a write frame -> all outputs at reset values, no WrStb, no FrameErr; following write frame succeeds.

Source files
------------

// File: rtl/spi_port.sv
// SPI register-access slave: 16-bit instruction (R/Wn, byte count, start address) followed
// by data bytes; the address decrements after every byte and the parent supplies the register file.
module spi_port (
   input  logic        sclk,
   input  logic        reset,
   input  logic        csb,
   input  logic        sdi,
   output logic        sdo,
   output logic        sdo_en,
   output logic [12:0] Addr,
   output logic        WrStb,
   output logic [7:0]  WrData,
   input  logic [7:0]  RdData,
   output logic        FrameErr
);

   typedef enum logic [1:0] {INSTR, WRITE, READ, DONE} state_t;

   state_t      state_q, state_d;
   logic [3:0]  icnt_q, icnt_d;
   logic [2:0]  dcnt_q, dcnt_d;
   logic [1:0]  bcnt_q, bcnt_d;
   logic [14:0] ishift_q, ishift_d;
   logic [6:0]  dshift_q, dshift_d;
   logic [12:0] addr_q, addr_d;
   logic [1:0]  w_q, w_d;
   logic        ferr_q, ferr_d;

   always_comb begin
      state_d  = state_q;
      icnt_d   = icnt_q;
      dcnt_d   = dcnt_q;
      bcnt_d   = bcnt_q;
      ishift_d = ishift_q;
      dshift_d = dshift_q;
      addr_d   = addr_q;
      w_d      = w_q;
      ferr_d   = 1'b0;

      if (csb) begin
         // Counters still hold the last in-frame values here, so a partial word is visible.
         ferr_d  = (icnt_q != 4'd0) || (dcnt_q != 3'd0);
         state_d = INSTR;
         icnt_d  = 4'd0;
         dcnt_d  = 3'd0;
         bcnt_d  = 2'd0;
      end else begin
         case (state_q)
            INSTR: begin
               ishift_d = {ishift_q[13:0], sdi};
               icnt_d   = icnt_q + 4'd1;
               if (icnt_q == 4'd15) begin
                  addr_d  = {ishift_q[11:0], sdi};
                  w_d     = ishift_q[13:12];
                  dcnt_d  = 3'd0;
                  bcnt_d  = 2'd0;
                  state_d = ishift_q[14] ? READ : WRITE;
               end
            end
            WRITE, READ: begin
               dshift_d = {dshift_q[5:0], sdi};
               dcnt_d   = dcnt_q + 3'd1;
               if (dcnt_q == 3'd7) begin
                  addr_d = addr_q - 13'd1;
                  bcnt_d = bcnt_q + 2'd1;
                  // W=11 streams until csb rises; otherwise stop after W+1 bytes.
                  if ((w_q != 2'b11) && (bcnt_q == w_q))
                     state_d = DONE;
               end
            end
            DONE: begin
               state_d = DONE;
            end
            default: begin
               state_d = INSTR;
            end
         endcase
      end
   end

   always_ff @(posedge sclk) begin
      if (reset) begin
         state_q  <= INSTR;
         icnt_q   <= 4'd0;
         dcnt_q   <= 3'd0;
         bcnt_q   <= 2'd0;
         ishift_q <= 15'd0;
         dshift_q <= 7'd0;
         addr_q   <= 13'd0;
         w_q      <= 2'd0;
         ferr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         icnt_q   <= icnt_d;
         dcnt_q   <= dcnt_d;
         bcnt_q   <= bcnt_d;
         ishift_q <= ishift_d;
         dshift_q <= dshift_d;
         addr_q   <= addr_d;
         w_q      <= w_d;
         ferr_q   <= ferr_d;
      end
   end

   assign Addr     = addr_q;
   assign FrameErr = ferr_q;
   assign WrStb    = (state_q == WRITE) && (dcnt_q == 3'd7) && !csb;
   assign WrData   = {dshift_q, sdi};
   assign sdo_en   = (state_q == READ) && !csb;
   assign sdo      = sdo_en & RdData[3'd7 - dcnt_q];

endmodule

// File: tb/tb_spi_port.sv
// Directed bench for spi_port: table of whole frames checked bit by bit, plus abort and
// mid-frame reset sequences.
module tb_spi_port;

   logic        sclk;
   logic        reset;
   logic        csb;
   logic        sdi;
   logic        sdo;
   logic        sdo_en;
   logic [12:0] Addr;
   logic        WrStb;
   logic [7:0]  WrData;
   logic [7:0]  RdData;
   logic        FrameErr;

   spi_port dut (
      .sclk    (sclk),
      .reset   (reset),
      .csb     (csb),
      .sdi     (sdi),
      .sdo     (sdo),
      .sdo_en  (sdo_en),
      .Addr    (Addr),
      .WrStb   (WrStb),
      .WrData  (WrData),
      .RdData  (RdData),
      .FrameErr(FrameErr)
   );

   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   int n_checks = 0;
   int n_fail   = 0;

   // Values seen just before the rising edge (pre_) and just after it (post_).
   logic        pre_wrstb, pre_sdo_en, pre_sdo;
   logic [7:0]  pre_wrdata;
   logic [12:0] pre_addr;
   logic        post_wrstb, post_sdo_en, post_sdo, post_ferr;
   logic [12:0] post_addr;

   typedef struct {
      logic [15:0]      instr;
      int               nbytes;      // data bytes clocked in the frame
      logic [31:0]      data;        // byte 0 in [31:24]
      logic [7:0]       rd;          // value presented on RdData
      int               exp_active;  // bytes expected to transfer
      logic [3:0][12:0] exp_addr;    // Addr expected during each active byte
   } frame_t;

   frame_t vec [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clk_bit(input logic c, input logic d, input logic r);
      @(negedge sclk);
      csb = c; sdi = d; reset = r;
      #1;
      pre_wrstb  = WrStb;
      pre_wrdata = WrData;
      pre_sdo_en = sdo_en;
      pre_sdo    = sdo;
      pre_addr   = Addr;
      @(posedge sclk);
      #1;
      post_wrstb  = WrStb;
      post_sdo_en = sdo_en;
      post_sdo    = sdo;
      post_ferr   = FrameErr;
      post_addr   = Addr;
   endtask

   task automatic run_frame(input int vi, input frame_t v);
      logic [7:0] byte_v;
      logic       is_rd;
      logic       active;
      is_rd  = v.instr[15];
      RdData = v.rd;
      for (int i = 15; i >= 0; i--) clk_bit(1'b0, v.instr[i], 1'b0);
      chk($sformatf("v%0d_addr_load", vi), {19'd0, post_addr}, {19'd0, v.exp_addr[0]});
      for (int k = 0; k < v.nbytes; k++) begin
         byte_v = v.data[31 - 8*k -: 8];
         active = (k < v.exp_active);
         for (int b = 0; b < 8; b++) begin
            clk_bit(1'b0, byte_v[7-b], 1'b0);
            if (is_rd) begin
               chk($sformatf("v%0d_k%0d_b%0d_sdo_en", vi, k, b), {31'd0, pre_sdo_en}, {31'd0, active});
               chk($sformatf("v%0d_k%0d_b%0d_sdo", vi, k, b), {31'd0, pre_sdo},
                   {31'd0, active & v.rd[7-b]});
               if (b == 7) chk($sformatf("v%0d_k%0d_wrstb", vi, k), {31'd0, pre_wrstb}, 32'd0);
            end else begin
               chk($sformatf("v%0d_k%0d_b%0d_wrstb", vi, k, b), {31'd0, pre_wrstb},
                   {31'd0, active && (b == 7)});
               if (b == 7) chk($sformatf("v%0d_k%0d_sdo_en", vi, k), {31'd0, pre_sdo_en}, 32'd0);
               if (b == 7 && active)
                  chk($sformatf("v%0d_k%0d_wrdata", vi, k), {24'd0, pre_wrdata}, {24'd0, byte_v});
            end
            if (b == 7 && active)
               chk($sformatf("v%0d_k%0d_addr", vi, k), {19'd0, pre_addr}, {19'd0, v.exp_addr[k]});
         end
      end
      clk_bit(1'b1, 1'b0, 1'b0);
      chk($sformatf("v%0d_ferr_clean", vi), {31'd0, post_ferr}, 32'd0);
      chk($sformatf("v%0d_sdo_en_idle", vi), {31'd0, post_sdo_en}, 32'd0);
   endtask

   initial begin
      logic [15:0] ins;
      reset = 1'b1; csb = 1'b1; sdi = 1'b0; RdData = 8'h00;

      vec[0] = '{16'h0014, 2, 32'hA5C3_0000, 8'h00, 1, {13'h0, 13'h0, 13'h0, 13'h0014}};
      vec[1] = '{16'h4100, 4, 32'h1122_3344, 8'h00, 3, {13'h0, 13'h00FE, 13'h00FF, 13'h0100}};
      vec[2] = '{16'h8008, 2, 32'h0000_0000, 8'h3C, 1, {13'h0, 13'h0, 13'h0, 13'h0008}};
      vec[3] = '{16'hE001, 3, 32'h0000_0000, 8'h96, 3, {13'h0, 13'h1FFF, 13'h0000, 13'h0001}};
      vec[4] = '{16'h6000, 4, 32'hDEAD_BEEF, 8'h00, 4, {13'h1FFD, 13'h1FFE, 13'h1FFF, 13'h0000}};
      vec[5] = '{16'hA123, 3, 32'h0000_0000, 8'h5A, 2, {13'h0, 13'h0, 13'h0122, 13'h0123}};

      // Reset state, with csb low to show reset wins.
      clk_bit(1'b1, 1'b0, 1'b1);
      clk_bit(1'b0, 1'b1, 1'b1);
      chk("rst_addr",   {19'd0, post_addr},  32'd0);
      chk("rst_wrstb",  {31'd0, post_wrstb}, 32'd0);
      chk("rst_sdo_en", {31'd0, post_sdo_en}, 32'd0);
      chk("rst_sdo",    {31'd0, post_sdo},   32'd0);
      chk("rst_ferr",   {31'd0, post_ferr},  32'd0);
      clk_bit(1'b1, 1'b0, 1'b0);
      chk("rst_release_ferr", {31'd0, post_ferr}, 32'd0);

      for (int vi = 0; vi < 6; vi++) run_frame(vi, vec[vi]);

      // Aborted write: 16 instruction edges plus 4 data edges, then csb high.
      ins = 16'h0014;
      for (int i = 15; i >= 0; i--) clk_bit(1'b0, ins[i], 1'b0);
      for (int b = 0; b < 4; b++) begin
         clk_bit(1'b0, 1'b1, 1'b0);
         chk($sformatf("abort_b%0d_wrstb", b), {31'd0, pre_wrstb}, 32'd0);
      end
      clk_bit(1'b1, 1'b0, 1'b0);
      chk("abort_ferr_pulse", {31'd0, post_ferr}, 32'd1);
      chk("abort_no_wrstb", {31'd0, pre_wrstb}, 32'd0);
      clk_bit(1'b1, 1'b0, 1'b0);
      chk("abort_ferr_one_cycle", {31'd0, post_ferr}, 32'd0);

      // Abort inside the instruction word.
      ins = 16'h8123;
      for (int i = 15; i >= 11; i--) clk_bit(1'b0, ins[i], 1'b0);
      clk_bit(1'b1, 1'b0, 1'b0);
      chk("instr_abort_ferr", {31'd0, post_ferr}, 32'd1);
      clk_bit(1'b1, 1'b0, 1'b0);
      chk("instr_abort_ferr_clear", {31'd0, post_ferr}, 32'd0);

      // Reset at edge 10 of a write frame; Addr still holds 0x0014 from the aborted frame.
      ins = 16'h0014;
      for (int i = 15; i >= 7; i--) clk_bit(1'b0, ins[i], 1'b0);
      clk_bit(1'b0, ins[6], 1'b1);
      chk("midrst_addr",   {19'd0, post_addr},  32'd0);
      chk("midrst_wrstb",  {31'd0, post_wrstb}, 32'd0);
      chk("midrst_sdo_en", {31'd0, post_sdo_en}, 32'd0);
      chk("midrst_sdo",    {31'd0, post_sdo},   32'd0);
      chk("midrst_ferr",   {31'd0, post_ferr},  32'd0);
      clk_bit(1'b1, 1'b0, 1'b0);
      chk("midrst_no_ferr", {31'd0, post_ferr}, 32'd0);
      run_frame(10, vec[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
